// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage constants, state type and opcode helper
package cpu_pkg;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [15:0] PC_INC = 16'd2;
  localparam logic [15:0] RESET_PC = 16'h0000;
  typedef enum logic [1:0] {REQ, DROP, HALT} fetch_state_t;
  function automatic logic isHalt(input logic [15:0] inst);
    return inst[15:12] == OP_HLT;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory request/response bus
interface fetch_stage_if;
  logic imem_req;
  logic [15:0] imem_addr;
  logic imem_ack;
  logic [15:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer holding a response that arrived while decode was stalled
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [15:0] loadInst,
  input  logic [15:0] loadPc,
  output logic        full,
  output logic [15:0] inst,
  output logic [15:0] pc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= 1'b0;
      inst <= '0;
      pc <= '0;
    end else begin
      full <= !clear && (load || (full && !drain));
      if (load) begin
        inst <= loadInst;
        pc <= loadPc;
      end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch FSM and IF/ID register; redirects squash in-flight
// responses by waiting out the old request in DROP.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [15:0]   br_target,
  fetch_stage_if.master imem,
  output logic [15:0]   if_inst,
  output logic [15:0]   if_pc,
  output logic [15:0]   if_pcinc,
  output logic          if_valid,
  output logic          halt_fetched
);
  fetch_state_t state, nextState;
  logic [15:0] pc, dropAddr, skidInst, skidPc, loadInst, loadPc;
  logic skidFull, accept, fetchOk, skidLoad, drain, ifLoad;

  fetch_skid skid (
    .clk(clk), .rst(rst), .load(skidLoad), .drain(drain), .clear(br_taken),
    .loadInst(imem.imem_rdata), .loadPc(pc), .full(skidFull), .inst(skidInst), .pc(skidPc)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= REQ;
    else state <= nextState;

  always_comb begin
    imem.imem_req = !rst && (state == DROP || (state == REQ && !skidFull));
    imem.imem_addr = state == DROP ? dropAddr : pc;
    accept = imem.imem_req && imem.imem_ack;
    fetchOk = accept && state == REQ;
    drain = !br_taken && !stall && skidFull;
    skidLoad = !br_taken && stall && fetchOk;
    ifLoad = drain || (!br_taken && !stall && fetchOk);
    loadInst = drain ? skidInst : imem.imem_rdata;
    loadPc = drain ? skidPc : pc;
    nextState = br_taken ? (imem.imem_req && !imem.imem_ack ? DROP : REQ)
              : ifLoad && isHalt(loadInst) ? HALT
              : state == DROP && accept ? REQ : state;
  end

  // in DROP the held address is re-captured unchanged, so a second redirect only moves pc
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      dropAddr <= RESET_PC;
      if_inst <= '0;
      if_pc <= '0;
      if_pcinc <= '0;
      if_valid <= 1'b0;
      halt_fetched <= 1'b0;
    end else if (br_taken) begin
      pc <= br_target;
      dropAddr <= imem.imem_addr;
      if_valid <= 1'b0;
      halt_fetched <= 1'b0;
    end else begin
      if (fetchOk) pc <= pc + PC_INC;
      if (!stall) if_valid <= ifLoad;
      if (ifLoad) begin
        if_inst <= loadInst;
        if_pc <= loadPc;
        if_pcinc <= loadPc + PC_INC;
      end
      if (ifLoad && isHalt(loadInst)) halt_fetched <= 1'b1;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios then random traffic, checked against a behavioural fetch model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst, stall, br_taken;
  logic [15:0] br_target, if_inst, if_pc, if_pcinc;
  logic if_valid, halt_fetched;
  int compared = 0;
  int mismatched = 0;

  fetch_stage_if imem();

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem(imem), .if_inst(if_inst), .if_pc(if_pc), .if_pcinc(if_pcinc),
    .if_valid(if_valid), .halt_fetched(halt_fetched)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] inst; logic [15:0] pc;} entry_t;
  entry_t skidQ[$];
  logic [15:0] mPc, mDropAddr, eInst, ePc, ePcinc;
  logic dropping, halted, eValid, eHalt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 16'h0000;
    mDropAddr = 16'h0000;
    dropping = 1'b0;
    halted = 1'b0;
    skidQ.delete();
    {eInst, ePc, ePcinc, eValid, eHalt} = '0;
  endtask

  task automatic present(input logic [15:0] inst, input logic [15:0] pc);
    eInst = inst;
    ePc = pc;
    ePcinc = pc + 16'd2;
    eValid = 1'b1;
    if (inst[15:12] == 4'hF) begin
      halted = 1'b1;
      eHalt = 1'b1;
    end
  endtask

  task automatic checkReset();
    chk("rst_imem_req", 16'(imem.imem_req), 16'h0);
    chk("rst_if_valid", 16'(if_valid), 16'h0);
    chk("rst_if_inst", if_inst, 16'h0000);
    chk("rst_if_pc", if_pc, 16'h0000);
    chk("rst_if_pcinc", if_pcinc, 16'h0000);
    chk("rst_halt", 16'(halt_fetched), 16'h0);
  endtask

  task automatic step(input logic st, input logic br, input logic [15:0] tgt, input logic ack,
                      input logic [15:0] rd);
    logic expReq, got;
    logic [15:0] expAddr;
    entry_t e;
    stall = st;
    br_taken = br;
    br_target = tgt;
    imem.imem_ack = ack;
    imem.imem_rdata = rd;
    #1;
    expReq = !rst && !halted && (dropping || skidQ.size() == 0);
    expAddr = dropping ? mDropAddr : mPc;
    chk("imem_req", 16'(imem.imem_req), 16'(expReq));
    if (expReq) chk("imem_addr", imem.imem_addr, expAddr);
    got = expReq && ack;
    if (!rst) begin
      if (br) begin
        if (expReq && !ack) begin
          if (!dropping) mDropAddr = expAddr;
          dropping = 1'b1;
        end else dropping = 1'b0;
        halted = 1'b0;
        mPc = tgt;
        eValid = 1'b0;
        eHalt = 1'b0;
        skidQ.delete();
      end else if (dropping) begin
        if (got) dropping = 1'b0;
        if (!st) eValid = 1'b0;
      end else begin
        if (!st && skidQ.size() != 0) begin
          e = skidQ.pop_front();
          present(e.inst, e.pc);
        end else if (!st && got) present(rd, mPc);
        else if (!st) eValid = 1'b0;
        if (got && st) skidQ.push_back('{rd, mPc});
        if (got) mPc = mPc + 16'd2;
      end
    end
    @(posedge clk);
    #1;
    chk("if_valid", 16'(if_valid), 16'(eValid));
    if (eValid) begin
      chk("if_inst", if_inst, eInst);
      chk("if_pc", if_pc, ePc);
      chk("if_pcinc", if_pcinc, ePcinc);
    end
    chk("halt_fetched", 16'(halt_fetched), 16'(eHalt));
  endtask

  initial begin
    rst = 1'b1;
    {stall, br_taken, br_target, imem.imem_ack, imem.imem_rdata} = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    rst = 1'b0;
    // streaming with zero-wait acks
    step(0, 0, 0, 1, 16'h1234);
    chk("stream_pc0", if_pc, 16'h0000);
    step(0, 0, 0, 1, 16'h5678);
    chk("stream_pc1", if_pc, 16'h0002);
    chk("stream_inc1", if_pcinc, 16'h0004);
    // stall with ack at pc=4 lands in the skid
    step(1, 0, 0, 1, 16'h0ABC);
    chk("skid_frozen_pc", if_pc, 16'h0002);
    chk("skid_req_off", 16'(imem.imem_req), 16'h0);
    step(1, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 16'h0000);
    chk("skid_drain_pc", if_pc, 16'h0004);
    chk("skid_resume_addr", imem.imem_addr, 16'h0006);
    // redirect while the request at 8 is outstanding
    step(0, 0, 0, 1, 16'h1111);
    step(0, 0, 0, 0, 16'h0000);
    step(0, 1, 16'h0040, 0, 16'h0000);
    chk("drop_old_addr", imem.imem_addr, 16'h0008);
    step(0, 0, 0, 1, 16'hDEAD);
    chk("drop_discard", 16'(if_valid), 16'h0);
    chk("drop_new_addr", imem.imem_addr, 16'h0040);
    step(0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 16'h2222);
    chk("drop_first_pc", if_pc, 16'h0040);
    // halt fetched at pc=10, then squashed by a redirect
    step(0, 1, 16'h000A, 0, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 1, 16'hF000);
    chk("halt_set", 16'(halt_fetched), 16'h1);
    chk("halt_req_off", 16'(imem.imem_req), 16'h0);
    step(0, 0, 0, 1, 16'h4444);
    step(0, 0, 0, 1, 16'h4444);
    step(0, 1, 16'h0020, 0, 16'h0000);
    chk("halt_cleared", 16'(halt_fetched), 16'h0);
    chk("halt_redirect_addr", imem.imem_addr, 16'h0020);
    // reset in the middle of an outstanding request at 0x12
    step(0, 1, 16'h0012, 0, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    chk("pre_rst_addr", imem.imem_addr, 16'h0012);
    #2;
    rst = 1'b1;
    #1;
    checkReset();
    modelReset();
    step(0, 0, 0, 1, 16'h5555);
    rst = 1'b0;
    #1;
    chk("post_rst_req", 16'(imem.imem_req), 16'h1);
    chk("post_rst_addr", imem.imem_addr, 16'h0000);
    // wrap-around at the top of the address space
    step(0, 1, 16'hFFFE, 1, 16'h0000);
    step(0, 0, 0, 1, 16'h3333);
    chk("wrap_pc", if_pc, 16'hFFFE);
    chk("wrap_pcinc", if_pcinc, 16'h0000);
    chk("wrap_next_addr", imem.imem_addr, 16'h0000);
    // random traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(3) == 0, $urandom_range(15) == 0, 16'($urandom) & 16'hFFFE,
           $urandom_range(1) == 1, 16'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL expose `clk  in  1  sole clock`; all state changes on its rising edge.
REQ-002 The block SHALL expose `rst  in  1  reset`, asynchronous and active-high.
REQ-003 The block SHALL expose `stall  in  1  hold IF/ID register and PC (from hazard unit)`.
REQ-004 The block SHALL expose `br_taken  in  1  redirect request from EX`.
REQ-005 The block SHALL expose `br_target  in  16  redirect PC`.
REQ-006 The block SHALL expose `imem_req  out  1  instruction memory request`.
REQ-007 The block SHALL expose `imem_addr  out  16  fetch address`.
REQ-008 The block SHALL expose `imem_ack  in  1  response valid`.
REQ-009 The block SHALL expose `imem_rdata  in  16  fetched instruction`.
REQ-010 The block SHALL expose the IF/ID register as `if_inst out 16`, `if_pc out 16`, `if_pcinc out 16` and `if_valid out 1`.
REQ-011 The block SHALL expose `halt_fetched  out  1  halt instruction accepted, fetch stopped`.

Function
REQ-012 The block SHALL implement an FSM with states REQ, DROP and HALT.
REQ-013 In REQ and DROP, imem_req SHALL be 1 and imem_addr SHALL hold a stable address until imem_ack.
REQ-014 In HALT, imem_req SHALL be 0.
REQ-015 Memory latency is unbounded: on any cycle without ack, the outstanding request SHALL be held unchanged.
REQ-016 On REQ with ack, no stall, no br_taken, the IF/ID register SHALL load {imem_rdata, pc, pc+2, 1} and pc SHALL become pc+2, giving 1-cycle latency from ack to if_valid.
REQ-017 pc arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000.
REQ-018 When REQ with ack coincides with stall=1, the response SHALL be captured in a 1-entry skid buffer {inst, pc}, pc SHALL advance, and new requests SHALL be suppressed while the skid is full.
REQ-019 On the first cycle with stall=0 and the skid full, the skid SHALL load IF/ID and then be marked empty.
REQ-020 While stall=1, IF/ID SHALL hold its value.
REQ-021 br_taken SHALL have priority over stall and ack.
REQ-022 On br_taken: pc<=br_target; if_valid<=0; skid<=empty; halt_fetched<=0.
REQ-023 On br_taken, the next state SHALL be DROP if a request is outstanding without ack in the same cycle; otherwise REQ.
REQ-024 In DROP, the block SHALL keep requesting the old address, discard the data on ack, and then enter REQ at the redirected pc.
REQ-025 A second br_taken in DROP SHALL update pc only; the FSM SHALL remain in DROP.
REQ-026 When an instruction with imem_rdata[15:12]==OP_HLT is loaded into IF/ID (directly or from the skid), the FSM SHALL enter HALT and halt_fetched SHALL be set to 1.
REQ-027 halt_fetched SHALL remain set until br_taken or rst.
REQ-028 In HALT, br_taken (a speculative halt squashed) SHALL return the FSM to REQ at br_target.
REQ-029 With the skid empty and no other cause, if_valid SHALL be 0 on any cycle where the IF/ID register does not load an instruction (bubble).
REQ-030 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-031 Asynchronous assertion of rst SHALL set: pc=RESET_PC (16'h0000), state=REQ, skid empty, if_inst=16'h0000, if_pc=0, if_pcinc=0, if_valid=0, halt_fetched=0.
REQ-032 While rst=1, imem_req SHALL be forced to 0.
REQ-033 imem_req SHALL assert on the first cycle after rst deasserts.
REQ-034 rst mid-request SHALL abandon the request; a late ack arriving after reset with imem_req=0 SHALL be ignored.

Structure
REQ-035 Shared package cpu_pkg SHALL hold: OP_HLT=4'hF, PC_INC=16'd2, RESET_PC=16'h0000, and the fetch_state_t enum {REQ, DROP, HALT}.
REQ-036 A single sub-module fetch_skid (1-entry buffer: load, drain, clear, full flag) SHALL be instantiated.
REQ-037 The PC, FSM and IF/ID register SHALL reside in fetch_stage; the target size is 120-400 RTL lines.

Verification
REQ-038 Streaming: 0-wait ack every cycle, rdata=16'h1234/16'h5678 -> if_pc 0,2 on consecutive cycles, if_pcinc 2,4, if_valid=1.
REQ-039 Stall+ack: ack at pc=4 with stall=1 for 3 cycles -> IF/ID frozen, imem_req=0 while skid full; after stall drops, if_pc=4 next cycle, then fetch resumes at 6.
REQ-040 Redirect with outstanding request: req at 8 unacked, br_taken to 16'h0040 -> state DROP, ack at 8 discarded, next imem_addr=16'h0040, if_valid=0 until its ack.
REQ-041 Halt: rdata=16'hF000 at pc=10 -> halt_fetched=1, imem_req=0 thereafter; a later br_taken to 16'h0020 -> halt_fetched=0, imem_addr=16'h0020.
REQ-042 Reset mid-operation: rst pulsed while a request is outstanding at pc=16'h0012 -> all outputs at reset values asynchronously, first post-reset imem_addr=16'h0000.
REQ-043 Wrap-around: br_target=16'hFFFE with ack -> if_pcinc=16'h0000, next imem_addr=16'h0000.
